// File: rtl/nodf_module_status_monitor.sv
// nodf_module_status_monitor: block-level handshake status tracker for one non-dataflow HLS module
//   Tracks the module's phase, ready cycles, completed transactions, last start-to-done latency and
//   cycles stalled waiting for ap_continue. Everything is frozen once finish is sampled high.
//   Optional min/max latency outputs exist only when NODF_STATUS_MINMAX_EN is defined.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   ap_start, ap_ready  monitored module start / ready
//   ap_done             monitored module done
//   ap_continue         downstream continue
//   finish              end of run, freezes all outputs until reset
//   state               0 IDLE, 1 ACTIVE, 2 WAIT_CONT, 3 FROZEN
//   ready_count         cycles with ap_ready high (saturating)
//   done_count          completed transactions (saturating)
//   last_latency        start-to-done cycles of the latest transaction
//   stall_cycles        cycles spent in WAIT_CONT (saturating)
//   frozen              high once finish has been sampled
//   min_latency         smallest latency seen (NODF_STATUS_MINMAX_EN only)
//   max_latency         largest latency seen (NODF_STATUS_MINMAX_EN only)
module nodf_module_status_monitor #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] ready_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] stall_cycles,
`ifdef NODF_STATUS_MINMAX_EN
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
`endif
    output logic             frozen
);
    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CONT, FROZEN} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t st, st_nx;
    logic [CNT_W-1:0] lat_cnt, lat_nx, rc_nx, dc_nx, ll_nx, sc_nx;
    logic fr_nx, lat_upd;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction
    always_comb begin
        st_nx   = st;
        lat_nx  = lat_cnt;
        rc_nx   = ready_count;
        dc_nx   = done_count;
        ll_nx   = last_latency;
        sc_nx   = stall_cycles;
        fr_nx   = frozen;
        lat_upd = 1'b0;
        // finish wins over every same-cycle update; FROZEN only leaves via reset
        if (st != FROZEN) begin
            if (finish) begin
                st_nx = FROZEN;
                fr_nx = 1'b1;
            end else begin
                rc_nx = ap_ready ? sat_inc(ready_count) : ready_count;
                case (st)
                    IDLE: begin
                        // start tied low: completions are still counted, latency unknown
                        dc_nx  = (ap_done && ap_continue) ? sat_inc(done_count) : done_count;
                        st_nx  = ap_start ? ACTIVE : IDLE;
                        lat_nx = ap_start ? ONE : lat_cnt;
                    end
                    ACTIVE: begin
                        if (!ap_done) begin
                            lat_nx = sat_inc(lat_cnt);
                        end else begin
                            ll_nx   = lat_cnt;
                            lat_upd = 1'b1;
                            if (ap_continue) begin
                                dc_nx  = sat_inc(done_count);
                                st_nx  = ap_start ? ACTIVE : IDLE;
                                lat_nx = ap_start ? ONE : lat_cnt;
                            end else begin
                                st_nx = WAIT_CONT;
                            end
                        end
                    end
                    WAIT_CONT: begin
                        // a start seen while stalled is not accepted
                        sc_nx = sat_inc(stall_cycles);
                        dc_nx = ap_continue ? sat_inc(done_count) : done_count;
                        st_nx = ap_continue ? IDLE : WAIT_CONT;
                    end
                    default: ;
                endcase
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            st           <= IDLE;
            lat_cnt      <= '0;
            ready_count  <= '0;
            done_count   <= '0;
            last_latency <= '0;
            stall_cycles <= '0;
            frozen       <= 1'b0;
        end else begin
            st           <= st_nx;
            lat_cnt      <= lat_nx;
            ready_count  <= rc_nx;
            done_count   <= dc_nx;
            last_latency <= ll_nx;
            stall_cycles <= sc_nx;
            frozen       <= fr_nx;
        end
    end
`ifdef NODF_STATUS_MINMAX_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            min_latency <= '1;
            max_latency <= '0;
        end else if (lat_upd) begin
            min_latency <= (lat_cnt < min_latency) ? lat_cnt : min_latency;
            max_latency <= (lat_cnt > max_latency) ? lat_cnt : max_latency;
        end
    end
`endif
    assign state = st;
endmodule

// File: tb/tb_nodf_module_status_monitor.sv
// tb_nodf_module_status_monitor: scoreboard bench for the status monitor, full-width and 4-bit instances
module tb_nodf_module_status_monitor;
    logic clock = 1'b0;
    logic reset, ap_start, ap_ready, ap_done, ap_continue, finish;
    logic [1:0] state, state4;
    logic [31:0] ready_count, done_count, last_latency, stall_cycles;
    logic [3:0] ready_count4, done_count4, last_latency4, stall_cycles4;
    logic frozen, frozen4;
`ifdef NODF_STATUS_MINMAX_EN
    logic [31:0] min_latency, max_latency;
    logic [3:0] min_latency4, max_latency4;
`endif
    always #5 clock = ~clock;

    nodf_module_status_monitor #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish), .state(state), .ready_count(ready_count),
        .done_count(done_count), .last_latency(last_latency), .stall_cycles(stall_cycles),
`ifdef NODF_STATUS_MINMAX_EN
        .min_latency(min_latency), .max_latency(max_latency),
`endif
        .frozen(frozen));

    nodf_module_status_monitor #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish), .state(state4), .ready_count(ready_count4),
        .done_count(done_count4), .last_latency(last_latency4), .stall_cycles(stall_cycles4),
`ifdef NODF_STATUS_MINMAX_EN
        .min_latency(min_latency4), .max_latency(max_latency4),
`endif
        .frozen(frozen4));

    typedef struct {
        int st;
        longint rc, dc, ll, sc, mn, mx;
        bit fr;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;

    // reference model: unbounded counts; saturation applied when comparing against a given width
    int m_st;
    longint m_cyc, m_start, m_rc, m_dc, m_ll, m_sc, m_mn, m_mx;
    bit m_fr;
    localparam longint NONE = 64'd1 << 40;

    function automatic longint sat(input longint v, input longint m);
        return v > m ? m : v;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_latency(input longint n);
        m_ll = n;
        m_mn = n < m_mn ? n : m_mn;
        m_mx = n > m_mx ? n : m_mx;
    endtask

    task automatic model(input bit r, s, rd, d, c, f);
        exp_t e;
        if (r) begin
            m_st = 0; m_rc = 0; m_dc = 0; m_ll = 0; m_sc = 0; m_fr = 0; m_mn = NONE; m_mx = 0;
        end else if (m_fr) begin
        end else if (f) begin
            m_st = 3; m_fr = 1;
        end else begin
            if (rd) m_rc++;
            if (m_st == 0) begin
                if (d && c) m_dc++;
                if (s) begin m_st = 1; m_start = m_cyc; end
            end else if (m_st == 1) begin
                if (d) begin
                    note_latency(m_cyc - m_start);
                    if (!c) m_st = 2;
                    else begin
                        m_dc++;
                        m_st = s ? 1 : 0;
                        if (s) m_start = m_cyc;
                    end
                end
            end else if (m_st == 2) begin
                m_sc++;
                if (c) begin m_dc++; m_st = 0; end
            end
        end
        m_cyc++;
        e.st = m_st; e.rc = m_rc; e.dc = m_dc; e.ll = m_ll; e.sc = m_sc; e.fr = m_fr;
        e.mn = m_mn; e.mx = m_mx;
        q.push_back(e);
    endtask

    // drives one clock cycle of inputs from a negedge and returns at the following negedge
    task automatic cyc(input bit r, s, rd, d, c, f);
        reset = r; ap_start = s; ap_ready = rd; ap_done = d; ap_continue = c; finish = f;
        model(r, s, rd, d, c, f);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic txn(input int n);
        cyc(0, 1, 0, 0, 1, 0);
        idle(n - 1);
        cyc(0, 0, 0, 1, 1, 0);
    endtask

    // monitor: every clock edge presents a fresh registered status snapshot
    initial forever begin
        exp_t e;
        @(posedge clock);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("state", state, e.st);
            cmp("ready_count", ready_count, e.rc);
            cmp("done_count", done_count, e.dc);
            cmp("last_latency", last_latency, e.ll);
            cmp("stall_cycles", stall_cycles, e.sc);
            cmp("frozen", frozen, e.fr);
            cmp("state_w4", state4, e.st);
            cmp("ready_count_w4", ready_count4, sat(e.rc, 15));
            cmp("done_count_w4", done_count4, sat(e.dc, 15));
            cmp("last_latency_w4", last_latency4, sat(e.ll, 15));
            cmp("stall_cycles_w4", stall_cycles4, sat(e.sc, 15));
            cmp("frozen_w4", frozen4, e.fr);
`ifdef NODF_STATUS_MINMAX_EN
            cmp("min_latency", min_latency, sat(e.mn, 64'hFFFF_FFFF));
            cmp("max_latency", max_latency, e.mx);
            cmp("min_latency_w4", min_latency4, sat(e.mn, 15));
            cmp("max_latency_w4", max_latency4, sat(e.mx, 15));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        m_cyc = 0;
        @(negedge clock);
        // single transaction, latency 5
        cyc(1, 0, 0, 0, 1, 0);
        idle(1);
        txn(5);
        cmp("t1_latency", last_latency, 5);
        cmp("t1_done", done_count, 1);
        cmp("t1_state", state, 0);
        // continue held low for four cycles after done
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cmp("t2_stall", stall_cycles, 4);
        cmp("t2_done", done_count, 1);
        cmp("t2_latency", last_latency, 3);
        // ready pulses with start tied low
        cyc(1, 0, 0, 0, 1, 0);
        repeat (6) begin cyc(0, 0, 1, 0, 1, 0); idle(1); end
        cmp("t3_ready", ready_count, 6);
        cmp("t3_done", done_count, 0);
        cmp("t3_state", state, 0);
        // finish coinciding with done
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        idle(1);
        cyc(0, 0, 1, 1, 1, 1);
        repeat (4) cyc(0, 1, 1, 1, 1, 0);
        cmp("t4_state", state, 3);
        cmp("t4_frozen", frozen, 1);
        cmp("t4_done", done_count, 0);
        cmp("t4_ready", ready_count, 0);
        // back-to-back transactions
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        idle(1);
        cyc(0, 1, 0, 1, 1, 0);
        idle(3);
        cyc(0, 0, 0, 1, 1, 0);
        cmp("t5_done", done_count, 2);
        cmp("t5_latency", last_latency, 4);
        // latencies 5, 2, 9 then reset while active
        cyc(1, 0, 0, 0, 1, 0);
        txn(5); txn(2); txn(9);
        cmp("t6_latency", last_latency, 9);
`ifdef NODF_STATUS_MINMAX_EN
        cmp("t6_min", min_latency, 2);
        cmp("t6_max", max_latency, 9);
`endif
        cyc(0, 1, 0, 0, 1, 0);
        idle(2);
        cyc(1, 1, 1, 0, 1, 0);
        cmp("t6_reset_state", state, 0);
        cmp("t6_reset_done", done_count, 0);
        cmp("t6_reset_latency", last_latency, 0);
        txn(3);
        cmp("t6_after_reset_latency", last_latency, 3);
        // saturation on the narrow instance
        cyc(1, 0, 0, 0, 1, 0);
        txn(20);
        repeat (20) cyc(0, 0, 1, 0, 1, 0);
        cmp("sat_latency_w32", last_latency, 20);
        cmp("sat_latency_w4", last_latency4, 15);
        cmp("sat_ready_w4", ready_count4, 15);
        // randomized segments
        for (int seg = 0; seg < 6; seg++) begin
            cyc(1, 0, 0, 0, 1, 0);
            repeat (300)
                cyc(0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 70,
                    $urandom_range(0, 399) == 0);
        end
        @(posedge clock);
        @(negedge clock);
        cmp("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
